// File: rtl/fw_config_chain_ctrl.sv
// fw_config_chain_ctrl: shifts a buffered bit-stream onto the config chain, captures readback, then pulses config_load
module fw_config_chain_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int CLK_DIV     = 4,
    parameter int LOAD_CYCLES = 4
) (
    input  logic                              fw_clk,
    input  logic                              fw_rst_n,
    input  logic                              fw_enable,
    input  logic                              start,
    input  logic [$clog2(DEPTH*DATA_W+1)-1:0] num_bits,
    input  logic                              wr_en,
    input  logic [$clog2(DEPTH)-1:0]          wr_addr,
    input  logic [DATA_W-1:0]                 wr_data,
    input  logic [$clog2(DEPTH)-1:0]          rd_addr,
    output logic [DATA_W-1:0]                 rd_data,
    output logic                              busy,
    output logic                              done,
    output logic                              abort,
    output logic                              err,
    output logic                              fw_config_clk,
    output logic                              fw_config_in,
    output logic                              fw_config_load,
    input  logic                              fw_config_out
);
    localparam int NW = $clog2(DEPTH*DATA_W+1);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(DATA_W);
    localparam int DW = $clog2(CLK_DIV);
    localparam int LW = LOAD_CYCLES > 1 ? $clog2(LOAD_CYCLES) : 1;

    typedef enum logic [2:0] {IDLE, SHIFT_LO, SHIFT_HI, LOAD_GAP, LOAD, DONE} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       div_cnt_q, div_cnt_d;
    logic [LW-1:0]       load_cnt_q, load_cnt_d;
    logic [NW-1:0]       bit_idx_q, bit_idx_d, num_bits_q, num_bits_d;
    logic                busy_q, busy_d, done_q, done_d, abort_q, abort_d, err_q, err_d;
    logic                cfg_clk_q, cfg_clk_d, cfg_in_q, cfg_in_d, cfg_load_q, cfg_load_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [DATA_W-1:0]   tx_mem [DEPTH];
    logic [DATA_W-1:0]   rb_mem [DEPTH];
    logic                accept, active, div_last, capture, fetch;

    always_comb begin
        accept     = start && state_q == IDLE && fw_enable && num_bits != '0 && num_bits <= NW'(DEPTH*DATA_W);
        active     = state_q inside {SHIFT_LO, SHIFT_HI, LOAD_GAP, LOAD};
        div_last   = div_cnt_q == DW'(CLK_DIV-1);
        capture    = state_q == SHIFT_LO && div_last && fw_enable;
        state_d    = state_q;
        div_cnt_d  = (state_q inside {SHIFT_LO, SHIFT_HI, LOAD_GAP} && !div_last) ? div_cnt_q + 1'b1 : '0;
        load_cnt_d = state_q == LOAD ? load_cnt_q + 1'b1 : '0;
        bit_idx_d  = bit_idx_q;
        num_bits_d = num_bits_q;
        cfg_in_d   = cfg_in_q;
        abort_d    = 1'b0;
        err_d      = start && !accept;
        fetch      = 1'b0;
        case (state_q)
            IDLE: if (accept) begin
                state_d    = SHIFT_LO;
                bit_idx_d  = '0;
                num_bits_d = num_bits;
                fetch      = 1'b1;
            end
            SHIFT_LO: state_d = div_last ? SHIFT_HI : SHIFT_LO;
            SHIFT_HI: if (div_last) begin
                if (bit_idx_q == num_bits_q - 1'b1) begin
                    state_d  = LOAD_GAP;
                    cfg_in_d = 1'b0;
                end else begin
                    state_d   = SHIFT_LO;
                    bit_idx_d = bit_idx_q + 1'b1;
                    fetch     = 1'b1;
                end
            end
            LOAD_GAP: state_d = div_last ? LOAD : LOAD_GAP;
            LOAD:     state_d = load_cnt_q == LW'(LOAD_CYCLES-1) ? DONE : LOAD;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        // the data bit only ever changes on entry to a low phase, from the updated index
        if (fetch) cfg_in_d = tx_mem[bit_idx_d[BW +: AW]][bit_idx_d[BW-1:0]];
        if (active && !fw_enable) begin
            state_d   = IDLE;
            cfg_in_d  = 1'b0;
            div_cnt_d = '0;
            abort_d   = 1'b1;
        end
        busy_d     = state_d inside {SHIFT_LO, SHIFT_HI, LOAD_GAP, LOAD};
        cfg_clk_d  = state_d == SHIFT_HI;
        cfg_load_d = state_d == LOAD;
        done_d     = state_d == DONE;
        rd_data_d  = rb_mem[rd_addr];
    end

    always_ff @(posedge fw_clk or negedge fw_rst_n) begin
        if (!fw_rst_n) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            load_cnt_q <= '0;
            bit_idx_q  <= '0;
            num_bits_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            err_q      <= 1'b0;
            cfg_clk_q  <= 1'b0;
            cfg_in_q   <= 1'b0;
            cfg_load_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            load_cnt_q <= load_cnt_d;
            bit_idx_q  <= bit_idx_d;
            num_bits_q <= num_bits_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            err_q      <= err_d;
            cfg_clk_q  <= cfg_clk_d;
            cfg_in_q   <= cfg_in_d;
            cfg_load_q <= cfg_load_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // buffers survive reset so a sequence can be rerun without rewriting
    always_ff @(posedge fw_clk) begin
        if (wr_en && state_q == IDLE) tx_mem[wr_addr] <= wr_data;
        if (capture) rb_mem[bit_idx_q[BW +: AW]][bit_idx_q[BW-1:0]] <= fw_config_out;
    end

    assign rd_data        = rd_data_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign abort          = abort_q;
    assign err            = err_q;
    assign fw_config_clk  = cfg_clk_q;
    assign fw_config_in   = cfg_in_q;
    assign fw_config_load = cfg_load_q;
endmodule

// File: doc/fw_config_chain_ctrl.md
Name: fw_config_chain_ctrl

Overview:
Firmware-side controller for one fw_dev_id slot. It serializes a buffered configuration bit-stream onto the DUT config shift chain (config_clk, config_in), captures the chain's returning config_out bits for readback, and finishes with a config_load pulse. Its fw_config_* outputs feed one bit-lane of the FW-to-DUT mux/IOB stage. Its fw_config_out input is taken from that stage's registered input lane.

Parameters:
DATA_W, 32, buffer word width.
DEPTH, 8, number of buffer words; max chain length = DEPTH*DATA_W bits.
CLK_DIV, 4, fw_clk cycles per config_clk half-period; legal range >= 3, which covers the 2-cycle IOB round trip.
LOAD_CYCLES, 4, fw_clk cycles config_load is held high.

Ports:
fw_clk  in  1  firmware clock.
fw_rst_n  in  1  reset, asynchronous, active-low.
fw_enable  in  1  this slot is selected in the dev-id mux.
start  in  1  single-cycle request to run one shift+load sequence.
num_bits  in  $clog2(DEPTH*DATA_W+1)  chain length in bits; sampled on an accepted start.
wr_en  in  1  write strobe for the transmit buffer.
wr_addr  in  $clog2(DEPTH)  transmit buffer word address.
wr_data  in  DATA_W  transmit buffer word.
rd_addr  in  $clog2(DEPTH)  readback buffer word address.
rd_data  out  DATA_W  readback word; registered, 1-cycle latency.
busy  out  1  sequence in progress.
done  out  1  1-cycle pulse when a sequence completes.
abort  out  1  1-cycle pulse when fw_enable drops mid-sequence.
err  out  1  1-cycle pulse when a start is rejected.
fw_config_clk  out  1  to mux/IOB stage.
fw_config_in  out  1  to mux/IOB stage.
fw_config_load  out  1  to mux/IOB stage.
fw_config_out  in  1  from mux/IOB stage (already registered).

Behaviour:
- Reset (asynchronous, fw_rst_n=0):
  - State = IDLE.
  - All outputs 0, including rd_data.
  - Counters cleared.
  - Buffers are not cleared.
  - Asserting reset mid-sequence forces outputs to 0 immediately; no done or abort is issued.
- Registering and bit order:
  - All outputs are registered.
  - Bit k of the stream is word k/DATA_W, bit k%DATA_W (LSB first, word 0 first).
- Writes:
  - wr_en is honoured only in IDLE; it is ignored while busy.
- Start acceptance:
  - A start is accepted only in IDLE with fw_enable=1 and 1 <= num_bits <= DEPTH*DATA_W.
  - Otherwise err pulses in the next cycle and state is unchanged.
  - A start seen while busy is ignored and pulses err.
- State machine:
  - IDLE: busy=0. An accepted start loads bit_idx=0 and div_cnt=0, drives fw_config_in=bit0 and busy=1, then goes to SHIFT_LO.
  - SHIFT_LO: fw_config_clk=0 for CLK_DIV cycles.
    - On the last cycle, fw_config_out is written to readback bit bit_idx.
    - Then go to SHIFT_HI.
  - SHIFT_HI: fw_config_clk=1 for CLK_DIV cycles.
    - On the last cycle with bit_idx==num_bits-1, go to LOAD_GAP.
    - Otherwise bit_idx++, fw_config_in takes the next bit, and go to SHIFT_LO.
    - fw_config_in changes only at the HI->LO transition.
  - LOAD_GAP: fw_config_clk=0 and fw_config_in=0 for CLK_DIV cycles, then go to LOAD.
  - LOAD: fw_config_load=1 for LOAD_CYCLES cycles, then go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then go to IDLE.
- Latency:
  - start accepted to done asserted = 2*CLK_DIV*num_bits + CLK_DIV + LOAD_CYCLES + 1 fw_clk cycles.
  - Exactly num_bits rising edges appear on fw_config_clk.
- Readback:
  - Readback bit k equals the chain output before rising edge k, i.e. the previous chain content.
  - Readback bits >= num_bits keep their prior values.
  - rd_data is readable at any time; its value is meaningful after done.
- Abort:
  - fw_enable=0 in any non-IDLE state gives next cycle: outputs 0, abort=1 for 1 cycle, IDLE.
  - No config_load is issued on abort.
  - The readback buffer keeps partial data.
- Simultaneous events:
  - If the fw_enable drop and the last LOAD cycle coincide, abort takes priority (done is not issued).
  - A start in the DONE cycle is rejected with err.
- Counter widths:
  - div_cnt is $clog2(CLK_DIV) bits and bit_idx matches num_bits width.
  - Neither counter wraps within a legal sequence.

Test Plan:
- CLK_DIV=4, LOAD_CYCLES=4, word0=0x000000A5, num_bits=8, fw_enable=1, start:
  - fw_config_in bits sequence 1,0,1,0,0,1,0,1, each stable across its HI phase.
  - 8 config_clk rising edges, each high 4 cycles.
  - config_load high 4 cycles; done exactly 73 cycles after start; busy low afterwards.
- Loopback bench (8-bit DUT chain model behind the 2-cycle IOB delay, preloaded 0x3C), then run the above:
  - rd_addr=0 returns rd_data[7:0]=0x3C; the chain model holds 0xA5 after load.
- num_bits=256 with all 8 words written:
  - 256 edges; bit 255 = word7[31]; done at 2*4*256+9 = 2057 cycles; bit_idx never wraps.
- Rejected starts:
  - num_bits=0 -> err, no activity.
  - num_bits=257 -> err.
  - fw_enable=0 at start -> err.
  - start while busy -> err, sequence unaffected.
- fw_enable dropped after 3 bits:
  - abort pulse; outputs 0 next cycle; no config_load; readback bits 0..2 updated.
  - Next start runs normally.
- fw_rst_n asserted asynchronously mid SHIFT_HI:
  - fw_config_clk and busy fall without waiting for a clock edge.
  - After release: IDLE, with buffers still holding the written words.
